// File: rtl/io_display_scheduler_pkg.sv
// Shared constants for the display scheduler: default hold time, FSM
// encodings and the IO addresses the CPU-side decode uses to reach this block.
package io_display_scheduler_pkg;

  localparam int unsigned ONE_SEC = 100_000_000;

  localparam logic [0:0] SCHED_IDLE = 1'b0;
  localparam logic [0:0] SCHED_SHOW = 1'b1;

  localparam logic [31:0] IO_SEG_ADDR   = 32'hFFFF_0010;
  localparam logic [31:0] IO_BLINK_ADDR = 32'hFFFF_0014;

  // Width needed for a down-counter whose largest load value is hold-1.
  function automatic int unsigned timer_width(input int unsigned hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage

// File: rtl/io_display_scheduler_sync_fifo.sv
// Circular queue of display words with occupancy count, synchronous clear
// and a look-ahead port exposing the entry behind the head.
module io_display_scheduler_sync_fifo #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned DATA_W = 24,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [DATA_W-1:0] next_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_en, pop_en;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  assign push_en = push && !full && !clear;
  assign pop_en  = pop && !empty && !clear;

  assign head_data = mem_q[head_q];
  assign next_data = mem_q[head_q + PTR_W'(1)];

  // Pointers are PTR_W bits wide, so the increments wrap DEPTH-1 -> 0.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_en) tail_d = tail_q + PTR_W'(1);
      if (pop_en)  head_d = head_q + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[tail_q] <= push_data;
  end

endmodule

// File: rtl/io_display_scheduler.sv
// Shows each queued display word for HOLD_CYCLES cycles, back to back, and
// runs the blink countdown.
//
//   state      | meaning
//   SCHED_IDLE | nothing displayed, seg_out = 0; loads head when queue non-empty
//   SCHED_SHOW | head word on seg_out, hold timer counting down to the pop
module io_display_scheduler
  import io_display_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned HOLD_CYCLES = ONE_SEC,
  parameter int unsigned CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  input  logic              flush,
  input  logic              blink_load,
  input  logic [31:0]       blink_cycles,
  output logic [DATA_W-1:0] seg_out,
  output logic              seg_active,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              blink_out
);

  localparam int unsigned TIMER_W = timer_width(HOLD_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(HOLD_CYCLES - 1);

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] seg_q, seg_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [31:0]       blink_q, blink_d;
  logic              blink_out_q, blink_out_d;
  logic              push_en, pop;
  logic [DATA_W-1:0] head_data, next_data;

  assign push_ready = !full && !flush;
  assign push_en    = push_valid && push_ready;

  io_display_scheduler_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push_en),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .next_data (next_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // On the pop edge the successor is either the entry behind the head or,
  // if the queue held only the displayed word, a push landing on that edge.
  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    timer_d = timer_q;
    pop     = 1'b0;
    if (flush) begin
      state_d = SCHED_IDLE;
      seg_d   = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        SCHED_IDLE: begin
          if (!empty) begin
            seg_d   = head_data;
            timer_d = TIMER_RELOAD;
            state_d = SCHED_SHOW;
          end
        end
        SCHED_SHOW: begin
          if (timer_q == '0) begin
            pop = 1'b1;
            if (count > CNT_W'(1)) begin
              seg_d   = next_data;
              timer_d = TIMER_RELOAD;
            end else if (push_en) begin
              seg_d   = push_data;
              timer_d = TIMER_RELOAD;
            end else begin
              seg_d   = '0;
              timer_d = '0;
              state_d = SCHED_IDLE;
            end
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        default: begin
          state_d = SCHED_IDLE;
          seg_d   = '0;
          timer_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    blink_out_d = (blink_q != '0);
    if (blink_load)           blink_d = blink_cycles;
    else if (blink_q != '0)   blink_d = blink_q - 32'd1;
    else                      blink_d = blink_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCHED_IDLE;
      seg_q       <= '0;
      timer_q     <= '0;
      blink_q     <= '0;
      blink_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      timer_q     <= timer_d;
      blink_q     <= blink_d;
      blink_out_q <= blink_out_d;
    end
  end

  assign seg_out    = seg_q;
  assign seg_active = (state_q == SCHED_SHOW);
  assign blink_out  = blink_out_q;

endmodule

// File: tb/tb_io_display_scheduler.sv
// Randomized and directed bench for io_display_scheduler against a
// queue-based model of the display rules (DEPTH=4, HOLD_CYCLES=4).
module tb_io_display_scheduler;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned HOLD   = 4;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              push_valid = 1'b0;
  logic [DATA_W-1:0] push_data = '0;
  logic              push_ready;
  logic              flush = 1'b0;
  logic              blink_load = 1'b0;
  logic [31:0]       blink_cycles = '0;
  logic [DATA_W-1:0] seg_out;
  logic              seg_active;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              blink_out;

  int n_cmp = 0;
  int n_bad = 0;

  // model: queue contents, whether the head is on display and how many
  // display cycles it still has, plus the blink countdown
  logic [DATA_W-1:0] mq[$];
  bit                m_show = 0;
  int                m_left = 0;
  longint unsigned   m_blink = 0;
  bit                m_bout = 0;

  io_display_scheduler #(
    .DEPTH       (DEPTH),
    .DATA_W      (DATA_W),
    .HOLD_CYCLES (HOLD),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .push_valid   (push_valid),
    .push_data    (push_data),
    .push_ready   (push_ready),
    .flush        (flush),
    .blink_load   (blink_load),
    .blink_cycles (blink_cycles),
    .seg_out      (seg_out),
    .seg_active   (seg_active),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .blink_out    (blink_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] m_seg();
    return m_show ? mq[0] : '0;
  endfunction

  task automatic step();
    bit accept;
    bit pre_show;
    int pre_size;
    if (rst) begin
      mq.delete();
      m_show = 0; m_left = 0; m_blink = 0; m_bout = 0;
      return;
    end
    accept = push_valid && !flush && (mq.size() < DEPTH);
    m_bout = (m_blink != 0);
    if (blink_load)        m_blink = blink_cycles;
    else if (m_blink != 0) m_blink = m_blink - 1;
    if (flush) begin
      mq.delete();
      m_show = 0; m_left = 0;
      return;
    end
    pre_show = m_show;
    pre_size = mq.size();
    if (pre_show && m_left == 1) begin
      void'(mq.pop_front());
      if (accept) mq.push_back(push_data);
      m_show = (mq.size() > 0);
      m_left = m_show ? HOLD : 0;
    end else if (pre_show) begin
      m_left--;
      if (accept) mq.push_back(push_data);
    end else begin
      if (pre_size > 0) begin
        m_show = 1;
        m_left = HOLD;
      end
      if (accept) mq.push_back(push_data);
    end
  endtask

  // Caller sets inputs at the negedge; this checks the combinational
  // status, clocks one edge through model and DUT, then checks registers.
  task automatic cycle();
    #1;
    chk("push_ready", {31'd0, push_ready}, {31'd0, (mq.size() < DEPTH) && !flush});
    chk("full", {31'd0, full}, {31'd0, mq.size() == DEPTH});
    chk("empty", {31'd0, empty}, {31'd0, mq.size() == 0});
    @(posedge clk);
    step();
    @(negedge clk);
    chk("seg_out", 32'(seg_out), 32'(m_seg()));
    chk("seg_active", {31'd0, seg_active}, {31'd0, m_show});
    chk("count", 32'(count), 32'(mq.size()));
    chk("blink_out", {31'd0, blink_out}, {31'd0, m_bout});
  endtask

  task automatic idle_inputs();
    rst = 0; push_valid = 0; flush = 0; blink_load = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  initial begin
    int highs;
    @(posedge clk);
    step();
    @(negedge clk);
    chk("rst_seg", 32'(seg_out), 32'h0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    do_reset();

    // single word: visible for exactly HOLD cycles, starting one edge late
    push_valid = 1; push_data = 24'h123456;
    cycle();
    push_valid = 0;
    chk("s1_cnt", 32'(count), 32'd1);
    chk("s1_lat", 32'(seg_out), 32'h0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("s1_show", 32'(seg_out), 32'h123456);
      chk("s1_act", {31'd0, seg_active}, 32'd1);
    end
    cycle();
    chk("s1_off", 32'(seg_out), 32'h0);
    chk("s1_empty", {31'd0, empty}, 32'd1);

    // three back-to-back words
    do_reset();
    push_valid = 1; push_data = 24'hA; cycle();
    push_data = 24'hB; cycle();
    push_data = 24'hC; cycle();
    push_valid = 0;
    chk("s2_cnt3", 32'(count), 32'd3);
    chk("s2_a", 32'(seg_out), 32'hA);
    repeat (3) cycle();
    chk("s2_b", 32'(seg_out), 32'hB);
    chk("s2_cnt2", 32'(count), 32'd2);
    repeat (4) cycle();
    chk("s2_c", 32'(seg_out), 32'hC);
    chk("s2_cnt1", 32'(count), 32'd1);
    repeat (4) cycle();
    chk("s2_cnt0", 32'(count), 32'd0);
    chk("s2_off", 32'(seg_out), 32'h0);

    // overfill: fifth push refused, refill after first pop
    do_reset();
    push_valid = 1;
    for (int i = 0; i < 4; i++) begin
      push_data = 24'h100 + 24'(i);
      cycle();
    end
    push_data = 24'hBAD;
    #1;
    chk("s3_full", {31'd0, full}, 32'd1);
    chk("s3_ready", {31'd0, push_ready}, 32'd0);
    cycle();
    push_valid = 0;
    chk("s3_cnt4", 32'(count), 32'd4);
    cycle();
    chk("s3_pop", 32'(count), 32'd3);
    push_valid = 1; push_data = 24'h104;
    cycle();
    push_valid = 0;
    chk("s3_refill", 32'(count), 32'd4);
    repeat (18) cycle();

    // flush mid-show with a concurrent push
    do_reset();
    push_valid = 1;
    for (int i = 0; i < 3; i++) begin
      push_data = 24'h200 + 24'(i);
      cycle();
    end
    flush = 1; push_data = 24'hDEAD;
    cycle();
    flush = 0; push_valid = 0;
    chk("s4_seg", 32'(seg_out), 32'h0);
    chk("s4_cnt", 32'(count), 32'd0);
    chk("s4_empty", {31'd0, empty}, 32'd1);
    repeat (6) cycle();
    chk("s4_quiet", 32'(seg_out), 32'h0);

    // blink: load 5, load 5 with reload 2, load 0 cancel
    do_reset();
    blink_load = 1; blink_cycles = 5; cycle();
    blink_load = 0;
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      highs += int'(blink_out);
    end
    chk("s5_load5", 32'(highs), 32'd5);
    blink_load = 1; blink_cycles = 5; cycle();
    blink_load = 0;
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin blink_load = 1; blink_cycles = 2; end
      cycle();
      blink_load = 0;
      highs += int'(blink_out);
    end
    chk("s5_reload", 32'(highs), 32'd5);
    blink_load = 1; blink_cycles = 9; cycle();
    blink_load = 0; repeat (2) cycle();
    blink_load = 1; blink_cycles = 0; cycle();
    blink_load = 0; cycle();
    chk("s5_cancel", {31'd0, blink_out}, 32'd0);

    // reset mid-show with blink running
    do_reset();
    push_valid = 1; push_data = 24'h301; blink_load = 1; blink_cycles = 20; cycle();
    push_data = 24'h302; blink_load = 0; cycle();
    push_valid = 0; repeat (2) cycle();
    rst = 1; cycle();
    rst = 0;
    chk("s6_seg", 32'(seg_out), 32'h0);
    chk("s6_act", {31'd0, seg_active}, 32'd0);
    chk("s6_blink", {31'd0, blink_out}, 32'd0);
    chk("s6_cnt", 32'(count), 32'd0);
    repeat (8) cycle();
    chk("s6_resid", 32'(seg_out), 32'h0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      flush        = ($urandom_range(0, 49) == 0);
      push_valid   = ($urandom_range(0, 99) < 35);
      push_data    = DATA_W'($urandom);
      blink_load   = ($urandom_range(0, 29) == 0);
      blink_cycles = 32'($urandom_range(0, 12));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/io_display_scheduler.md
Name: io_display_scheduler

Overview:
- Sequences the seven-segment display and blink indicator for the memory-mapped IO block.
- The CPU-side IO decode pushes 24-bit display words into a queue. This block shows each word for a fixed hold time, then advances to the next.
- Also owns the blink countdown.
- Replaces ad-hoc pointer/timer logic with a clean push handshake, explicit FSM, flush and occupancy status.

Parameters:
- DEPTH, 32, queue entries; power of two, at least 2.
- DATA_W, 24, display word width.
- HOLD_CYCLES, 100000000, cycles each word is displayed; at least 1. Defaults to One_Sec.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- push_valid  input  1  IO decode requests a write of push_data (seg address store).
- push_data  input  DATA_W  display word to enqueue.
- push_ready  output  1  queue can accept; equals !full && !flush.
- flush  input  1  discard all queued and displayed words.
- blink_load  input  1  load the blink counter (blink address store).
- blink_cycles  input  32  blink duration in cycles; 0 cancels.
- seg_out  output  DATA_W  word to the seg driver; 0 when nothing is shown.
- seg_active  output  1  a word is currently displayed.
- count  output  CNT_W  queued entries, including the one on display.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- blink_out  output  1  high while the blink counter is nonzero.

Behaviour:
- Reset:
  - Queue pointers, count, hold timer and blink counter all go to 0.
  - State goes to IDLE.
  - Outputs: seg_out=0, seg_active=0, blink_out=0, empty=1, full=0, push_ready=1.
- Push:
  - Accepted on a clock edge when push_valid && push_ready.
  - Data is written at the tail; the tail wraps DEPTH-1 to 0.
  - When full, a push is ignored. No error flag is raised; the word is lost.
- FSM states: IDLE and SHOW.
  - IDLE: seg_out=0 and seg_active=0. If count>0 at an edge, the head word is registered to seg_out, the timer is set to HOLD_CYCLES-1, and the FSM goes to SHOW.
  - SHOW: seg_out holds the head word. The timer decrements each cycle.
  - On the edge where the timer is 0, the head is popped and the head pointer wraps.
    - If entries remain after the pop, the next word loads directly (no blank cycle) and the timer reloads. The FSM stays in SHOW.
    - Otherwise seg_out becomes 0 and the FSM goes to IDLE.
  - Each word is therefore visible for exactly HOLD_CYCLES cycles.
- Latency: a push accepted at edge N into an empty, idle queue appears on seg_out after edge N+1.
- Simultaneous push and pop on the same edge:
  - count is unchanged.
  - push_ready is based on the pre-edge full, so a full queue does not accept a push even on a pop edge.
- Count stays in 0..DEPTH at all times.
- Flush:
  - At the edge it is sampled high: pointers and count clear, the FSM goes to IDLE and seg_out becomes 0 after that edge.
  - push_ready is low during flush, so a concurrent push is dropped.
  - Flush does not affect the blink counter.
- Blink:
  - blink_load writes blink_cycles into the counter, overriding any countdown in progress.
  - Otherwise the counter decrements while it is nonzero.
  - blink_out is registered: it is high on the cycle after the counter is observed nonzero. A load of N gives exactly N high cycles.
  - A load on the final decrement cycle wins.
- Reset mid-operation (mid-hold or mid-blink) returns to the reset values on the next edge. No partial state survives.
- Outputs are registered except push_ready, full and empty, which are combinational from the registered count.

Decomposition:
- Shared constants in includes/defines.v:
  - One_Sec.
  - FSM encodings SCHED_IDLE and SCHED_SHOW.
  - IO_SEG_ADDR and IO_BLINK_ADDR, used by the decode that drives push_valid and blink_load.
- One sub-module is natural: sync_fifo (DEPTH, DATA_W).
  - Provides: push, pop, head data, count, full, empty, clear.
- The scheduler FSM, hold timer and blink counter stay in io_display_scheduler.

Test Plan:
All scenarios use HOLD_CYCLES=4, DEPTH=4.
1. Reset, then push 0x123456 once: seg_out=0x123456 from the cycle after acceptance+1 for exactly 4 cycles, then 0; seg_active tracks this; empty returns to 1.
2. Back-to-back push of 0xA, 0xB, 0xC: seg_out shows 0xA(4), 0xB(4), 0xC(4) with no blank cycle between words; count goes 3, then 2, 1, 0.
3. Five pushes to an idle full-capacity test:
   - 4 are accepted; full=1 and push_ready=0 on the 5th, and its word is never displayed.
   - After the first pop, a push is accepted and count returns to 4.
4. Flush mid-SHOW with 3 words queued, plus a concurrent push_valid: the next cycle has seg_out=0, count=0 and empty=1; the pushed word is never displayed.
5. blink_load with 5: blink_out is high for exactly 5 cycles. Reload with 2 at cycle 3 gives 2 more high cycles. blink_load with 0 drops blink_out the next cycle.
6. Assert rst during SHOW with 2 words queued and blink active: on the next edge, all outputs take reset values; no residual word appears after rst deasserts.
